sram_word_array: RTL and testbench

Parametrised multi-word SRAM block, the next generation of our single-bit SRAM cell: DEPTH words of DATA_W bits with per-byte write masking and a registered one-cycle read. It adds a hardware clear sequencer that zeroes every word after reset, and flags accesses to out-of-range addresses. It sits behind the SOAFA datapath as the local scratch store and is accessed through a single valid/ready request port.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_clear_seq.sv | 63 ++++++
 rtl/sram_word_array.sv | 147 ++++++++++++++
 tb/tb_sram_word_array.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the multi-word SRAM block.
package sram_pkg;

    // Sequencer states: zero the array first, then serve requests.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Number of byte lanes in a word of the given width.
    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    // Every bit of rsp_rdata comes out of reset at this value.
    localparam bit RSP_RDATA_RST_BIT = 1'b0;

endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: walks every word once after reset, then hands over to RUN.
module sram_clear_seq
    import sram_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy,
    output logic              run
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e            state_reg;
    state_e            state_next;
    logic [ADDR_W-1:0] idx_reg;
    logic [ADDR_W-1:0] idx_next;

    // State and clear index registers; reset restarts the clear from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= CLEAR;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state: one word cleared per cycle, leave CLEAR after the last word.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            CLEAR: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = RUN;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    // Outputs decode straight from the state register.
    assign init_busy = (state_reg == CLEAR);
    assign run       = (state_reg == RUN);
    assign clr_we    = (state_reg == CLEAR);
    assign clr_addr  = idx_reg;

endmodule

// File: rtl/sram_word_array.sv
// DEPTH x DATA_W scratch store with byte-masked writes, one-cycle registered
// reads, out-of-range flagging and a hardware clear after reset.
module sram_word_array
    import sram_pkg::*;
#(
    parameter int  DATA_W      = 16,
    parameter int  DEPTH       = 8,
    parameter bit  WRITE_FIRST = 1'b1,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wmask,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_busy
);

    localparam int                LANES     = lane_count(DATA_W);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    // Elaboration-time parameter sanity checks.
    generate
        if (DATA_W % 8 != 0) begin : g_chk_data_w
            $error("sram_word_array: DATA_W must be a multiple of 8");
        end
        if (DEPTH < 2) begin : g_chk_depth
            $error("sram_word_array: DEPTH must be at least 2");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;

    logic              in_range;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LANES-1:0]  wr_lane_en;

    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] bypass_word;
    logic [DATA_W-1:0] rd_word;

    logic              rsp_valid_reg;
    logic              rsp_err_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;

    sram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy),
        .run       (run)
    );

    assign req_ready = run;

    // Handshake and range qualification; nothing is accepted while reset is held.
    assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign accept   = req_valid & req_ready & ~reset;
    assign wr_acc   = accept & req_we & in_range;
    assign rd_acc   = accept & ~req_we;

    // Single write port shared by the clear sequencer and accepted writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = req_addr;
        wr_data = req_wdata;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (wr_acc) begin
            wr_en = 1'b1;
        end
    end

    // Mask merge: a clear writes every lane, a request only its enabled bytes.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_lane_en[gi] = clr_we | (wr_acc & req_wmask[gi]);
            assign bypass_word[8*gi +: 8] = wr_lane_en[gi] ? wr_data[8*gi +: 8]
                                                          : mem_word[8*gi +: 8];
        end
    endgenerate

    // Byte-enabled memory write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_lane_en[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read source: optional same-cycle bypass, else the stored word; zero when out of range.
    assign mem_word = mem[req_addr];
    always_comb begin
        rd_word = mem_word;
        if (WRITE_FIRST && wr_en && (wr_addr == req_addr)) begin
            rd_word = bypass_word;
        end
        if (!in_range) begin
            rd_word = '0;
        end
    end

    // Response register: one-cycle pulse per read, data held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= {DATA_W{RSP_RDATA_RST_BIT}};
        end else begin
            rsp_valid_reg <= rd_acc;
            rsp_err_reg   <= rd_acc & ~in_range;
            if (rd_acc) begin
                rsp_rdata_reg <= rd_word;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_sram_word_array.sv
// Bench for sram_word_array: an 8-word write-first instance (A) and a
// 6-word read-first instance (B) driven from a shared vector table.
module tb_sram_word_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_wmask;

    logic        valid_a, ready_a, rsp_valid_a, rsp_err_a, busy_a;
    logic [15:0] rsp_rdata_a;
    logic        valid_b, ready_b, rsp_valid_b, rsp_err_b, busy_b;
    logic [15:0] rsp_rdata_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic        sel;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sram_word_array #(.DATA_W(16), .DEPTH(8), .WRITE_FIRST(1'b1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (valid_a),
        .req_ready (ready_a),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid_a),
        .rsp_rdata (rsp_rdata_a),
        .rsp_err   (rsp_err_a),
        .init_busy (busy_a)
    );

    sram_word_array #(.DATA_W(16), .DEPTH(6), .WRITE_FIRST(1'b0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (valid_b),
        .req_ready (ready_b),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid_b),
        .rsp_rdata (rsp_rdata_b),
        .rsp_err   (rsp_err_b),
        .init_busy (busy_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    function automatic void add(input logic sel, input logic we, input logic [2:0] addr,
                                input logic [15:0] wdata, input logic [1:0] wmask,
                                input logic [15:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.sel = sel; v.we = we; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Scoreboard for A: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid_a) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL rsp_a_unexpected got=%h err=%b want=no response", rsp_rdata_a, rsp_err_a);
            end else begin
                ea = qa.pop_front();
                if (rsp_rdata_a !== ea.d || rsp_err_a !== ea.e) begin
                    bad++;
                    $display("FAIL rsp_a got=%h err=%b want=%h err=%b", rsp_rdata_a, rsp_err_a, ea.d, ea.e);
                end else begin
                    $display("ok   rsp_a data=%h err=%b", rsp_rdata_a, rsp_err_a);
                end
            end
        end
    end

    // Scoreboard for B.
    always @(negedge clk) begin
        if (rsp_valid_b) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL rsp_b_unexpected got=%h err=%b want=no response", rsp_rdata_b, rsp_err_b);
            end else begin
                eb = qb.pop_front();
                if (rsp_rdata_b !== eb.d || rsp_err_b !== eb.e) begin
                    bad++;
                    $display("FAIL rsp_b got=%h err=%b want=%h err=%b", rsp_rdata_b, rsp_err_b, eb.d, eb.e);
                end else begin
                    $display("ok   rsp_b data=%h err=%b", rsp_rdata_b, rsp_err_b);
                end
            end
        end
    end

    // Drive one request for one cycle; reads push their expectation.
    task automatic issue(input vec_t v);
        exp_t x;
        valid_a   = (v.sel == 1'b0);
        valid_b   = (v.sel == 1'b1);
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wmask = v.wmask;
        if (!v.we) begin
            x.d = v.exp_rdata;
            x.e = v.exp_err;
            if (v.sel == 1'b0) qa.push_back(x);
            else               qb.push_back(x);
        end
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        valid_a   = 1'b0;
        valid_b   = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        repeat (2) @(posedge clk);
        #1;

        // Output values while reset is held.
        chk("rst_ready_a", ready_a, 0);
        chk("rst_busy_a", busy_a, 1);
        chk("rst_valid_a", rsp_valid_a, 0);
        chk("rst_err_a", rsp_err_a, 0);
        chk("rst_rdata_a", rsp_rdata_a, 0);
        chk("rst_ready_b", ready_b, 0);

        // Hold a write request through the clear; it must be ignored.
        valid_a   = 1'b1;
        valid_b   = 1'b1;
        req_we    = 1'b1;
        req_addr  = 3'd0;
        req_wdata = 16'hFFFF;
        req_wmask = 2'b11;
        reset     = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("clr_ready_a_%0d", i), ready_a, (i == 8));
            chk($sformatf("clr_busy_a_%0d", i), busy_a, (i != 8));
            chk($sformatf("clr_ready_b_%0d", i), ready_b, (i >= 6));
            if (i == 6) valid_b = 1'b0;
        end
        valid_a = 1'b0;

        // Vector table.
        for (int a = 0; a < 8; a++) add(1'b0, 1'b0, 3'(a), 16'h0, 2'b00, 16'h0000, 1'b0);
        add(1'b0, 1'b1, 3'd3, 16'hBEEF, 2'b11, 16'h0, 1'b0);
        add(1'b0, 1'b0, 3'd3, 16'h0,    2'b00, 16'hBEEF, 1'b0);
        add(1'b0, 1'b1, 3'd3, 16'h1234, 2'b01, 16'h0, 1'b0);
        add(1'b0, 1'b0, 3'd3, 16'h0,    2'b00, 16'hBE34, 1'b0);
        add(1'b0, 1'b1, 3'd3, 16'hFFFF, 2'b00, 16'h0, 1'b0);
        add(1'b0, 1'b0, 3'd3, 16'h0,    2'b00, 16'hBE34, 1'b0);
        add(1'b0, 1'b1, 3'd0, 16'hAAAA, 2'b11, 16'h0, 1'b0);
        add(1'b0, 1'b1, 3'd1, 16'h5555, 2'b10, 16'h0, 1'b0);
        add(1'b0, 1'b1, 3'd2, 16'h0F0F, 2'b11, 16'h0, 1'b0);
        add(1'b0, 1'b0, 3'd0, 16'h0,    2'b00, 16'hAAAA, 1'b0);
        add(1'b0, 1'b0, 3'd1, 16'h0,    2'b00, 16'h5500, 1'b0);
        add(1'b0, 1'b0, 3'd2, 16'h0,    2'b00, 16'h0F0F, 1'b0);
        add(1'b0, 1'b1, 3'd7, 16'h1357, 2'b10, 16'h0, 1'b0);
        add(1'b0, 1'b0, 3'd7, 16'h0,    2'b00, 16'h1300, 1'b0);
        add(1'b1, 1'b0, 3'd0, 16'h0,    2'b00, 16'h0000, 1'b0);
        add(1'b1, 1'b1, 3'd7, 16'hFFFF, 2'b11, 16'h0, 1'b0);
        add(1'b1, 1'b0, 3'd7, 16'h0,    2'b00, 16'h0000, 1'b1);
        add(1'b1, 1'b0, 3'd5, 16'h0,    2'b00, 16'h0000, 1'b0);
        add(1'b1, 1'b1, 3'd5, 16'hABCD, 2'b01, 16'h0, 1'b0);
        add(1'b1, 1'b0, 3'd5, 16'h0,    2'b00, 16'h00CD, 1'b0);
        add(1'b1, 1'b1, 3'd6, 16'h1111, 2'b11, 16'h0, 1'b0);
        add(1'b1, 1'b0, 3'd6, 16'h0,    2'b00, 16'h0000, 1'b1);
        add(1'b1, 1'b0, 3'd4, 16'h0,    2'b00, 16'h0000, 1'b0);
        for (int k = 0; k < vecs.size(); k++) issue(vecs[k]);

        // rsp_rdata holds its last value once rsp_valid drops.
        @(posedge clk);
        #1;
        chk("hold_valid_a", rsp_valid_a, 0);
        chk("hold_rdata_a", rsp_rdata_a, 16'h1300);
        chk("hold_valid_b", rsp_valid_b, 0);

        // Reset in the cycle after a read accept.
        begin
            vec_t v;
            v.sel = 1'b0; v.we = 1'b0; v.addr = 3'd3; v.wdata = 16'h0; v.wmask = 2'b00;
            v.exp_rdata = 16'hBE34; v.exp_err = 1'b0;
            issue(v);
        end
        reset    = 1'b1;
        valid_a  = 1'b1;
        req_we   = 1'b0;
        req_addr = 3'd0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid_a", rsp_valid_a, 0);
        chk("mid_rst_busy_a", busy_a, 1);
        chk("mid_rst_ready_a", ready_a, 0);
        reset   = 1'b0;
        valid_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("reclr_ready_a_%0d", i), ready_a, (i == 8));
        end
        vecs.delete();
        add(1'b0, 1'b0, 3'd3, 16'h0, 2'b00, 16'h0000, 1'b0);
        add(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 16'h0000, 1'b0);
        add(1'b1, 1'b0, 3'd5, 16'h0, 2'b00, 16'h0000, 1'b0);
        for (int k = 0; k < vecs.size(); k++) issue(vecs[k]);

        // Every expected response must have arrived within a few cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("pending_a", qa.size(), 0);
        chk("pending_b", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
